// File: rtl/rand_pkg.sv
// Shared constants and FSM state type for the random-word dispenser.
package rand_pkg;

  localparam logic [63:0] LFSR_POLY    = 64'h1B;
  localparam logic [63:0] DEFAULT_SEED = 64'h0c45f864_04e4684a;

  // WARMUP: LFSR free-runs to mix the seed; RUN: words handed out on grant.
  typedef enum logic {
    S_WARMUP = 1'b0,
    S_RUN    = 1'b1
  } rand_state_e;

endpackage : rand_pkg

// File: rtl/rand_dispenser_if.sv
// Request/grant and reseed signals between requesters and the dispenser.
interface rand_dispenser_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [WIDTH-1:0]   rand_data;
  logic [IW-1:0]      rand_id;
  logic               reseed_valid;
  logic [63:0]        reseed_value;
  logic               reseed_ready;
  logic               busy;

  // Requester / reseed-command side.
  modport master (
    output req, reseed_valid, reseed_value,
    input  gnt, rand_data, rand_id, reseed_ready, busy
  );

  // Dispenser side.
  modport slave (
    input  req, reseed_valid, reseed_value,
    output gnt, rand_data, rand_id, reseed_ready, busy
  );
endinterface : rand_dispenser_if

// File: rtl/lfsr64_step.sv
// One step of the 64-bit Galois LFSR, purely combinational.
module lfsr64_step
  import rand_pkg::*;
(
  input  logic [63:0] cur_i,
  output logic [63:0] nxt_o
);
  // Shift left; fold the outgoing MSB back through the feedback taps.
  always_comb begin
    nxt_o = {cur_i[62:0], 1'b0} ^ ({64{cur_i[63]}} & LFSR_POLY);
  end
endmodule : lfsr64_step

// File: rtl/rand_dispenser.sv
// Shared-LFSR random word dispenser with zero-latency round-robin grant.
module rand_dispenser
  import rand_pkg::*;
#(
  parameter int          NUM_REQ = 4,
  parameter int          WIDTH   = 32,
  parameter int          WARMUP  = 8,
  parameter logic [63:0] SEED    = DEFAULT_SEED
) (
  input logic              clk,
  input logic              reset,
  rand_dispenser_if.slave  bus
);
  localparam int IW = $clog2(NUM_REQ);

  rand_state_e  state_q, state_d;
  logic [63:0]  lfsr_q, lfsr_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [63:0]  lfsr_step;
  logic         found;
  logic [IW-1:0] sel;

  lfsr64_step u_step (
    .cur_i (lfsr_q),
    .nxt_o (lfsr_step)
  );

  // Round-robin search: first active request at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && bus.req[j]) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
  end

  // Next state and outputs; a reseed in RUN pre-empts any grant.
  always_comb begin
    state_d          = state_q;
    lfsr_d           = lfsr_q;
    cnt_d            = cnt_q;
    ptr_d            = ptr_q;
    bus.gnt          = '0;
    bus.rand_data    = '0;
    bus.rand_id      = '0;
    bus.reseed_ready = 1'b0;
    bus.busy         = 1'b1;
    unique case (state_q)
      S_WARMUP: begin
        lfsr_d = lfsr_step;
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q == 8'(WARMUP - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        bus.busy         = 1'b0;
        bus.reseed_ready = 1'b1;
        if (bus.reseed_valid) begin
          // An all-zero LFSR would lock up, so substitute the reset seed.
          lfsr_d  = (bus.reseed_value == 64'd0) ? SEED : bus.reseed_value;
          cnt_d   = '0;
          state_d = S_WARMUP;
        end else if (found) begin
          bus.gnt[sel]  = 1'b1;
          bus.rand_id   = sel;
          bus.rand_data = lfsr_q[WIDTH-1:0];
          lfsr_d        = lfsr_step;
          ptr_d         = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);
        end
      end
      default: state_d = S_WARMUP;
    endcase
    // Reset overrides whatever the current state would present.
    if (reset) begin
      bus.gnt          = '0;
      bus.rand_data    = '0;
      bus.rand_id      = '0;
      bus.reseed_ready = 1'b0;
      bus.busy         = 1'b1;
    end
  end

  // State registers; reset restarts a full warmup from the seed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WARMUP;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule : rand_dispenser

// File: tb/tb_rand_dispenser.sv
// Directed bench for rand_dispenser (NUM_REQ=4, WIDTH=32, WARMUP=8).
module tb_rand_dispenser;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  logic [63:0] exp_lfsr;

  always #5 clk = ~clk;

  rand_dispenser_if #(.NUM_REQ(4), .WIDTH(32)) bus ();

  rand_dispenser #(
    .NUM_REQ (4),
    .WIDTH   (32),
    .WARMUP  (8),
    .SEED    (64'h0c45f864_04e4684a)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Hand-derived: seed stepped 8 times, then successive RUN words (low 32).
  logic [31:0] w_tab [0:4];
  initial begin
    w_tab[0] = 32'he4684ab4;
    w_tab[1] = 32'hc8d09568;
    w_tab[2] = 32'h91a12acb;
    w_tab[3] = 32'h23425596;
    w_tab[4] = 32'h4684ab2c;
  end

  function automatic logic [63:0] nxt(input logic [63:0] v);
    return {v[62:0], 1'b0} ^ (v[63] ? 64'h1B : 64'h0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles (gnt must stay low) until RUN; expect exactly 8.
  task automatic wait_warmup(input string tag);
    int n;
    n = 0;
    #1;
    while (bus.busy && n < 40) begin
      chk({tag, "_gnt0"}, 64'(bus.gnt), 64'h0);
      n++;
      step();
      #1;
    end
    chk({tag, "_len"}, 64'(n), 64'd8);
  endtask

  initial begin
    reset            = 1'b1;
    bus.req          = '0;
    bus.reseed_valid = 1'b0;
    bus.reseed_value = '0;
    step();
    step();
    chk("rst_gnt",   64'(bus.gnt),          64'h0);
    chk("rst_data",  64'(bus.rand_data),    64'h0);
    chk("rst_id",    64'(bus.rand_id),      64'h0);
    chk("rst_ready", 64'(bus.reseed_ready), 64'h0);
    chk("rst_busy",  64'(bus.busy),         64'h1);
    reset = 1'b0;
    wait_warmup("wu_rst");

    // Single requester: consecutive LFSR words.
    bus.req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("solo_gnt",  64'(bus.gnt),       64'h1);
      chk("solo_id",   64'(bus.rand_id),   64'h0);
      chk("solo_data", 64'(bus.rand_data), 64'(w_tab[k]));
      step();
    end

    // Idle in RUN: no grant, LFSR holds.
    bus.req = '0;
    #1;
    chk("idle_gnt",   64'(bus.gnt),          64'h0);
    chk("idle_data",  64'(bus.rand_data),    64'h0);
    chk("idle_ready", 64'(bus.reseed_ready), 64'h1);
    chk("idle_busy",  64'(bus.busy),         64'h0);
    step();

    // Grant requester 3 to bring ptr back to 0.
    bus.req = 4'b1000;
    #1;
    chk("r3_gnt",  64'(bus.gnt),       64'h8);
    chk("r3_data", 64'(bus.rand_data), 64'(w_tab[4]));
    step();
    exp_lfsr = nxt(64'h5f86404e4684ab2c);

    // All requesting: rotate 0,1,2,3,0.
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_gnt",  64'(bus.gnt),       64'(4'b0001 << (k % 4)));
      chk("rr_id",   64'(bus.rand_id),   64'(k % 4));
      chk("rr_data", 64'(bus.rand_data), 64'(exp_lfsr[31:0]));
      exp_lfsr = nxt(exp_lfsr);
      step();
    end

    // Reseed with 1 while requester 1 waits: reseed wins.
    bus.req          = 4'b0010;
    bus.reseed_valid = 1'b1;
    bus.reseed_value = 64'h1;
    #1;
    chk("rs1_ready", 64'(bus.reseed_ready), 64'h1);
    chk("rs1_gnt",   64'(bus.gnt),          64'h0);
    chk("rs1_data",  64'(bus.rand_data),    64'h0);
    step();
    bus.reseed_valid = 1'b0;
    wait_warmup("wu_rs1");
    chk("rs1_gnt2", 64'(bus.gnt),       64'h2);
    chk("rs1_id",   64'(bus.rand_id),   64'h1);
    chk("rs1_word", 64'(bus.rand_data), 64'h100);
    step();
    bus.req = '0;

    // Reseed with zero substitutes the reset seed.
    bus.reseed_valid = 1'b1;
    bus.reseed_value = 64'h0;
    #1;
    chk("rs0_ready", 64'(bus.reseed_ready), 64'h1);
    step();
    bus.reseed_valid = 1'b0;
    wait_warmup("wu_rs0");
    bus.req = 4'b0001;
    #1;
    chk("rs0_gnt",  64'(bus.gnt),       64'h1);
    chk("rs0_word", 64'(bus.rand_data), 64'(w_tab[0]));
    step();

    // Reset in RUN with requests pending suppresses outputs.
    bus.req = 4'b1111;
    reset   = 1'b1;
    #1;
    chk("rrun_gnt",  64'(bus.gnt),       64'h0);
    chk("rrun_data", 64'(bus.rand_data), 64'h0);
    chk("rrun_busy", 64'(bus.busy),      64'h1);
    bus.req = '0;
    step();
    reset = 1'b0;

    // Reset again at warmup count 5: full warmup restarts.
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_warmup("wu_mid");
    bus.req = 4'b1111;
    #1;
    chk("mid_gnt",  64'(bus.gnt),       64'h1);
    chk("mid_word", 64'(bus.rand_data), 64'(w_tab[0]));
    step();
    bus.req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule : tb_rand_dispenser
